pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control_pkg.sv | 28 ++
 rtl/pipeline_control_fwd_match.sv | 34 +++
 rtl/pipeline_control.sv | 155 +++++++++++++++
 tb/tb_pipeline_control.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forwarding
// selects, controller FSM states and the per-stage scoreboard entry.
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_PREV1 = 2'd1,
        FWD_PREV2 = 2'd2,
        FWD_PREV3 = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd_addr;
        logic       is_load;
    } sb_entry_t;

    function automatic logic entry_hit(input sb_entry_t e, input logic [4:0] addr);
        return e.valid && (e.rd_addr == addr);
    endfunction

endpackage

// File: rtl/pipeline_control_fwd_match.sv
// Forwarding select for one ID source operand against the EX/M/WB scoreboard.
// Also flags a load-use hazard when the youngest match is a load still in EX.
module fwd_match
    import pipeline_control_pkg::*;
(
    input  logic [4:0] src_addr_i,
    input  logic       src_use_i,
    input  sb_entry_t  ex_i,
    input  sb_entry_t  m_i,
    input  sb_entry_t  wb_i,
    output fwd_sel_t   sel_o,
    output logic       load_use_o
);

    logic active;

    assign active = src_use_i && (src_addr_i != 5'd0);

    always_comb begin
        sel_o      = FWD_REG;
        load_use_o = 1'b0;
        if (active) begin
            if (entry_hit(ex_i, src_addr_i)) begin
                sel_o      = FWD_PREV1;
                load_use_o = ex_i.is_load;
            end else if (entry_hit(m_i, src_addr_i)) begin
                sel_o = FWD_PREV2;
            end else if (entry_hit(wb_i, src_addr_i)) begin
                sel_o = FWD_PREV3;
            end
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush
// and ebreak drain/halt. Counters are built only with PIPELINE_CONTROL_PERF_EN.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_writeback_en,
    input  logic             id_is_load,
    input  logic             id_is_ebreak,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       rs1_sel,
    output logic [1:0]       rs2_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DCW = $clog2(DRAIN_CYCLES + 1) < 1 ? 1 : $clog2(DRAIN_CYCLES + 1);

    sb_entry_t   ex_q, m_q, wb_q, issue_entry;
    ctrl_state_t state_q, state_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;

    fwd_sel_t rs1_fwd, rs2_fwd;
    logic     rs1_lu, rs2_lu, load_use;
    logic     stall_c, flush_c, bubble_c, stall_event;

    fwd_match u_fwd_rs1 (
        .src_addr_i (id_rs1_addr),
        .src_use_i  (id_use_rs1),
        .ex_i       (ex_q),
        .m_i        (m_q),
        .wb_i       (wb_q),
        .sel_o      (rs1_fwd),
        .load_use_o (rs1_lu)
    );

    fwd_match u_fwd_rs2 (
        .src_addr_i (id_rs2_addr),
        .src_use_i  (id_use_rs2),
        .ex_i       (ex_q),
        .m_i        (m_q),
        .wb_i       (wb_q),
        .sel_o      (rs2_fwd),
        .load_use_o (rs2_lu)
    );

    assign load_use = rs1_lu || rs2_lu;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        bubble_c    = 1'b0;
        stall_event = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A taken branch squashes the younger load-use consumer, so it wins.
                flush_c     = ex_branch_taken;
                stall_event = load_use && !ex_branch_taken;
                stall_c     = stall_event;
                bubble_c    = stall_event || ex_branch_taken;
                if (id_valid && id_is_ebreak && !load_use && !ex_branch_taken) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DCW'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                flush_c  = ex_branch_taken;
                if (drain_cnt_q <= DCW'(1)) begin
                    state_d     = ST_HALTED;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            ST_HALTED: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        issue_entry.valid   = id_valid && id_writeback_en && (id_rd_addr != 5'd0) && !bubble_c;
        issue_entry.rd_addr = id_rd_addr;
        issue_entry.is_load = id_is_load;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q        <= '0;
            m_q         <= '0;
            wb_q        <= '0;
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
        end else begin
            wb_q        <= m_q;
            m_q         <= ex_q;
            ex_q        <= issue_entry;
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Control outputs are forced quiet while reset is being asserted.
    assign pc_stall     = rst && stall_c;
    assign if_id_stall  = rst && stall_c;
    assign if_id_flush  = rst && flush_c;
    assign id_ex_bubble = rst && bubble_c;
    assign rs1_sel      = rst ? rs1_fwd : FWD_REG;
    assign rs2_sel      = rst ? rs2_fwd : FWD_REG;
    assign halted       = (state_q == ST_HALTED);

`ifdef PIPELINE_CONTROL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != ST_HALTED) begin
            if (stall_event)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ex_branch_taken)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: a table of per-cycle ID/EX vectors with
// expected control/select outputs, then hand sequences for drain, halt and reset.
module tb_pipeline_control;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic             id_use_rs1, id_use_rs2, id_writeback_en, id_is_load, id_is_ebreak;
    logic             ex_branch_taken;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_bubble, halted;
    logic [1:0]       rs1_sel, rs2_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipeline_control #(.CNT_W(CNT_W), .DRAIN_CYCLES(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd_addr      (id_rd_addr),
        .id_writeback_en (id_writeback_en),
        .id_is_load      (id_is_load),
        .id_is_ebreak    (id_is_ebreak),
        .ex_branch_taken (ex_branch_taken),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .rs1_sel         (rs1_sel),
        .rs2_sel         (rs2_sel),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       eb;
        logic       br;
        logic [3:0] ctl;     // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble}
        logic [1:0] s1;
        logic [1:0] s2;
        logic       chk_sel;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic we, input logic ld, input logic eb, input logic br,
                                input logic [3:0] ctl, input logic [1:0] s1, input logic [1:0] s2,
                                input logic chk_sel);
        vec_t r;
        r = '{v, rs1, rs2, u1, u2, rd, we, ld, eb, br, ctl, s1, s2, chk_sel};
        return r;
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic eb, input logic br);
        id_valid        = v;
        id_rs1_addr     = rs1;
        id_rs2_addr     = rs2;
        id_use_rs1      = u1;
        id_use_rs2      = u2;
        id_rd_addr      = rd;
        id_writeback_en = we;
        id_is_load      = ld;
        id_is_ebreak    = eb;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [3:0] ctl_now();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_bubble};
    endfunction

    int exp_stall, exp_flush;

    initial begin
        // Row order matters: each row depends on scoreboard state left by earlier rows.
        tbl[0]  = mk(1,  0, 0, 0, 0,  5, 1, 0, 0, 0, 4'b0000, 0, 0, 1);
        tbl[1]  = mk(1,  5, 0, 1, 0,  6, 1, 0, 0, 0, 4'b0000, 1, 0, 1);
        tbl[2]  = mk(1,  5, 6, 1, 1,  0, 0, 0, 0, 0, 4'b0000, 2, 1, 1);
        tbl[3]  = mk(1,  5, 6, 1, 1,  0, 1, 0, 0, 0, 4'b0000, 3, 2, 1);
        tbl[4]  = mk(1,  0, 6, 1, 1,  5, 1, 1, 0, 0, 4'b0000, 0, 3, 1);
        tbl[5]  = mk(1,  0, 5, 0, 1,  0, 0, 0, 0, 0, 4'b1101, 0, 0, 0);
        tbl[6]  = mk(1,  0, 5, 0, 1,  0, 0, 0, 0, 0, 4'b0000, 0, 2, 1);
        tbl[7]  = mk(1,  0, 0, 0, 0,  7, 1, 1, 0, 0, 4'b0000, 0, 0, 1);
        tbl[8]  = mk(1,  7, 0, 1, 0,  0, 0, 0, 0, 1, 4'b0011, 0, 0, 0);
        tbl[9]  = mk(1,  7, 5, 1, 1,  7, 1, 0, 0, 0, 4'b0000, 2, 0, 1);
        tbl[10] = mk(0,  7, 7, 1, 0,  3, 1, 0, 0, 0, 4'b0000, 1, 0, 1);
        tbl[11] = mk(1,  7, 3, 1, 1,  0, 0, 0, 0, 0, 4'b0000, 2, 0, 1);
        tbl[12] = mk(1,  0, 0, 0, 0, 12, 1, 1, 0, 0, 4'b0000, 0, 0, 1);
        tbl[13] = mk(1, 12, 0, 1, 0,  0, 0, 0, 0, 0, 4'b1101, 0, 0, 0);
        tbl[14] = mk(1, 12, 0, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 0, 0, 1);

        // Reset with a branch pending: outputs must stay quiet.
        rst = 1'b0;
        idle();
        ex_branch_taken = 1'b1;
        tick();
        tick();
        #3;
        chk("reset_ctl", 32'(ctl_now()), 32'h0);
        chk("reset_sel", 32'({rs1_sel, rs2_sel}), 32'h0);
        rst = 1'b1;
        idle();
        tick();
        #3;
        chk("post_reset_halted", 32'(halted), 32'h0);
        chk("post_reset_stall_cnt", stall_cnt, 32'h0);
        chk("post_reset_flush_cnt", flush_cnt, 32'h0);
        chk("post_reset_ctl", 32'(ctl_now()), 32'h0);

        for (int i = 0; i < 15; i++) begin
            set_id(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
                   tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].eb, tbl[i].br);
            #3;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(tbl[i].ctl));
            if (tbl[i].chk_sel)
                chk($sformatf("vec%0d_sel", i), 32'({rs1_sel, rs2_sel}),
                    32'({tbl[i].s1, tbl[i].s2}));
            tick();
        end

`ifdef PIPELINE_CONTROL_PERF_EN
        exp_stall = 2; exp_flush = 1;
`else
        exp_stall = 0; exp_flush = 0;
`endif
        idle();
        #3;
        chk("table_stall_cnt", stall_cnt, 32'(exp_stall));
        chk("table_flush_cnt", flush_cnt, 32'(exp_flush));

        // ebreak alongside a taken branch is discarded.
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("ebreak_branch_ctl", 32'(ctl_now()), 32'h3);
        tick();
        idle();
        #3;
        chk("ebreak_discarded_ctl", 32'(ctl_now()), 32'h0);
        tick();

        // ebreak behind a load-use stall retries the following cycle.
        set_id(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        tick();
        set_id(1, 4, 0, 1, 0, 0, 0, 0, 1, 0);
        #3;
        chk("ebreak_stalled_ctl", 32'(ctl_now()), 32'hD);
        tick();
        #3;
        chk("ebreak_retry_ctl", 32'(ctl_now()), 32'h0);
        tick();
        idle();

        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("drain%0d_ctl", k), 32'(ctl_now()), 32'hD);
            chk($sformatf("drain%0d_halted", k), 32'(halted), 32'h0);
            tick();
        end

        // Branches while halted neither flush nor count.
        ex_branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("halt%0d_halted", k), 32'(halted), 32'h1);
            chk($sformatf("halt%0d_ctl", k), 32'(ctl_now()), 32'hD);
            tick();
        end
        ex_branch_taken = 1'b0;

`ifdef PIPELINE_CONTROL_PERF_EN
        exp_stall = 3; exp_flush = 2;
`else
        exp_stall = 0; exp_flush = 0;
`endif
        #3;
        chk("halt_stall_cnt", stall_cnt, 32'(exp_stall));
        chk("halt_flush_cnt", flush_cnt, 32'(exp_flush));
        tick();

        rst = 1'b0;
        #3;
        chk("halt_reset_ctl", 32'(ctl_now()), 32'h0);
        tick();
        rst = 1'b1;
        #3;
        chk("unhalt_halted", 32'(halted), 32'h0);
        chk("unhalt_ctl", 32'(ctl_now()), 32'h0);
        chk("unhalt_stall_cnt", stall_cnt, 32'h0);
        tick();

        // Reset in the middle of a drain returns straight to RUN.
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #3;
        chk("drain2_issue_ctl", 32'(ctl_now()), 32'h0);
        tick();
        idle();
        #3;
        chk("drain2_c1_ctl", 32'(ctl_now()), 32'hD);
        tick();
        set_id(0, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("drain2_c2_sel_pre", 32'(rs1_sel), 32'h3);
        rst = 1'b0;
        #2;
        chk("drain2_rst_ctl", 32'(ctl_now()), 32'h0);
        chk("drain2_rst_sel", 32'({rs1_sel, rs2_sel}), 32'h0);
        tick();
        rst = 1'b1;
        #3;
        chk("drain2_after_ctl", 32'(ctl_now()), 32'h0);
        chk("drain2_after_halted", 32'(halted), 32'h0);
        chk("drain2_after_sel", 32'(rs1_sel), 32'h0);
        tick();
        #3;
        chk("drain2_next_halted", 32'(halted), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
